// File: rtl/sprite_blitter_pkg.sv
// Shared CHIP-8 display constants, draw-engine state encoding and sprite row extraction.
// Used by sprite_blitter and sprite_row_shifter.
package sprite_blitter_pkg;

    localparam int FB_W        = 64;
    localparam int FB_H        = 32;
    localparam int SPRITE_ROWS = 15;
    localparam int SPRITE_BITS = SPRITE_ROWS * 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Row idx sits at the top byte after shifting; idx past the last row yields zero.
    function automatic logic [7:0] sprite_row(input logic [SPRITE_BITS-1:0] data,
                                              input logic [3:0]             idx);
        logic [SPRITE_BITS-1:0] shifted;
        shifted = data << {idx, 3'b000};
        return shifted[SPRITE_BITS-1 -: 8];
    endfunction

endpackage

// File: rtl/sprite_row_shifter.sv
// Places one 8-pixel sprite row at column x0 of a framebuffer row.
// SPRITE_WRAP_EN: pixels past the right edge wrap to column 0; otherwise they are clipped.
module sprite_row_shifter
    import sprite_blitter_pkg::*;
(
    input  logic [7:0]      row_i,
    input  logic [5:0]      x0,
    output logic [FB_W-1:0] mask
);

    logic [FB_W-1:0] placed;

    assign placed = {row_i, {(FB_W-8){1'b0}}};

`ifdef SPRITE_WRAP_EN
    // Rotate right; a left shift by 64 (x0 == 0) contributes nothing.
    assign mask = (placed >> x0) | (placed << (7'(FB_W) - {1'b0, x0}));
`else
    assign mask = placed >> x0;
`endif

endmodule

// File: rtl/sprite_blitter.sv
// CHIP-8 draw engine: clear/XOR-draw into a 64x32 framebuffer, collision flag for VF,
// registered row-scan read port. SPRITE_WRAP_EN selects wrapping instead of clipping.
module sprite_blitter
    import sprite_blitter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   gpu_clear,
    input  logic                   gpu_draw,
    input  logic [7:0]             vx,
    input  logic [7:0]             vy,
    input  logic [3:0]             n_bits,
    input  logic [SPRITE_BITS-1:0] sprite_data,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             vf_out,
    input  logic [4:0]             scan_row,
    output logic [FB_W-1:0]        scan_data
);

    state_t                 state;
    logic [5:0]             x0;
    logic [4:0]             y0;
    logic [3:0]             n;
    logic [SPRITE_BITS-1:0] sprite;
    logic [4:0]             idx;
    logic                   coll;
    logic                   is_draw;
    logic [FB_W-1:0]        fb [FB_H];

    logic [7:0]             cur_row;
    logic [FB_W-1:0]        mask;
    logic [4:0]             y_row;
    logic                   row_ok;
    logic                   unused_bits;

    // Origins are taken modulo the screen size, so the upper coordinate bits are dropped.
    assign unused_bits = ^{vx[7:6], vy[7:5]};

    assign cur_row = sprite_row(sprite, idx[3:0]);

    sprite_row_shifter u_shifter (
        .row_i (cur_row),
        .x0    (x0),
        .mask  (mask)
    );

`ifdef SPRITE_WRAP_EN
    always_comb begin
        y_row  = y0 + idx;
        row_ok = 1'b1;
    end
`else
    logic [5:0] y_sum;

    always_comb begin
        y_sum  = {1'b0, y0} + {1'b0, idx};
        y_row  = y_sum[4:0];
        row_ok = ~y_sum[5];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            vf_out    <= '0;
            scan_data <= '0;
            x0        <= '0;
            y0        <= '0;
            n         <= '0;
            sprite    <= '0;
            idx       <= '0;
            coll      <= 1'b0;
            is_draw   <= 1'b0;
            for (int unsigned r = 0; r < FB_H; r++) begin
                fb[r] <= '0;
            end
        end else begin
            // Non-blocking read returns the row as it was before this cycle's write.
            scan_data <= fb[scan_row];
            done      <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (gpu_clear || gpu_draw) begin
                        x0      <= vx[5:0];
                        y0      <= vy[4:0];
                        n       <= n_bits;
                        sprite  <= sprite_data;
                        idx     <= '0;
                        coll    <= 1'b0;
                        busy    <= 1'b1;
                        is_draw <= ~gpu_clear;
                        if (gpu_clear)
                            state <= CLEAR;
                        else if (n_bits == 4'd0)
                            state <= DONE;
                        else
                            state <= DRAW;
                    end
                end

                CLEAR: begin
                    fb[idx] <= '0;
                    idx     <= idx + 5'd1;
                    if (idx == 5'(FB_H - 1))
                        state <= DONE;
                end

                DRAW: begin
                    if (row_ok) begin
                        coll       <= coll | (|(fb[y_row] & mask));
                        fb[y_row]  <= fb[y_row] ^ mask;
                    end
                    idx <= idx + 5'd1;
                    if (idx[3:0] == n - 4'd1)
                        state <= DONE;
                end

                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (is_draw)
                        vf_out <= {7'b0, coll};
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomised self-checking bench for sprite_blitter against a per-pixel framebuffer model.
// Build with +define+SPRITE_WRAP_EN to check the wrapping variant.
module tb_sprite_blitter;

    logic         clk = 1'b0;
    logic         rst;
    logic         gpu_clear;
    logic         gpu_draw;
    logic [7:0]   vx;
    logic [7:0]   vy;
    logic [3:0]   n_bits;
    logic [119:0] sprite_data;
    logic         busy;
    logic         done;
    logic [7:0]   vf_out;
    logic [4:0]   scan_row;
    logic [63:0]  scan_data;

    logic [63:0]  fb_m [32];
    logic [7:0]   vf_m;
    int           checks   = 0;
    int           failures = 0;

    sprite_blitter dut (
        .clk         (clk),
        .rst         (rst),
        .gpu_clear   (gpu_clear),
        .gpu_draw    (gpu_draw),
        .vx          (vx),
        .vy          (vy),
        .n_bits      (n_bits),
        .sprite_data (sprite_data),
        .busy        (busy),
        .done        (done),
        .vf_out      (vf_out),
        .scan_row    (scan_row),
        .scan_data   (scan_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) fb_m[r] = '0;
        vf_m = 8'h00;
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) fb_m[r] = '0;
    endtask

    // Pixel-by-pixel XOR plot, following the CHIP-8 drawing rules.
    task automatic model_draw(input logic [7:0] x, input logic [7:0] y, input int nn,
                              input logic [119:0] data);
        bit   hit = 0;
        logic [7:0] rb;
        int   col, row;
        for (int r = 0; r < nn; r++) begin
            rb = 8'(data >> (112 - 8 * r));
            for (int b = 0; b < 8; b++) begin
                if (rb[7 - b]) begin
                    col = (x % 64) + b;
                    row = (y % 32) + r;
`ifdef SPRITE_WRAP_EN
                    col = col % 64;
                    row = row % 32;
`else
                    if (col > 63 || row > 31) continue;
`endif
                    if (fb_m[row][63 - col]) hit = 1;
                    fb_m[row][63 - col] = ~fb_m[row][63 - col];
                end
            end
        end
        vf_m = hit ? 8'h01 : 8'h00;
    endtask

    task automatic read_row(input int r, output logic [63:0] v);
        @(negedge clk);
        scan_row = 5'(r);
        @(negedge clk);
        v = scan_data;
    endtask

    task automatic scan_all(input string tag);
        logic [63:0] v;
        for (int r = 0; r < 32; r++) begin
            read_row(r, v);
            check($sformatf("%s_row%0d", tag, r), v, fb_m[r]);
        end
    endtask

    // Issues one command, holds it until done, and checks busy, latency and VF.
    task automatic run_cmd(input logic c, input logic d, input logic [7:0] x, input logic [7:0] y,
                           input logic [3:0] nn, input logic [119:0] data, input int pulse_at,
                           input string tag);
        int lat;
        int exp_lat;
        @(negedge clk);
        gpu_clear   = c;
        gpu_draw    = d;
        vx          = x;
        vy          = y;
        n_bits      = nn;
        sprite_data = data;
        @(posedge clk);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
            check({tag, "_busy"}, 64'(busy), 64'd1);
            if (pulse_at != 0 && lat == pulse_at) gpu_draw = 1'b1;
            else if (pulse_at != 0 && lat == pulse_at + 1) gpu_draw = 1'b0;
        end
        gpu_clear = 1'b0;
        gpu_draw  = 1'b0;
        if (c) begin
            model_clear();
            exp_lat = 33;
        end else begin
            model_draw(x, y, int'(nn), data);
            exp_lat = int'(nn) + 1;
        end
        check({tag, "_lat"},  64'(lat),    64'(exp_lat));
        check({tag, "_done"}, 64'(done),   64'd1);
        check({tag, "_idle"}, 64'(busy),   64'd0);
        check({tag, "_vf"},   64'(vf_out), 64'(vf_m));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    localparam logic [119:0] ZERO_GLYPH = {8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0, 80'h0};

    initial begin
        logic [63:0]  v;
        logic [63:0]  exp_edge;
        logic [127:0] rnd;
        logic         c, d;

        rst = 1'b1; gpu_clear = 1'b0; gpu_draw = 1'b0;
        vx = '0; vy = '0; n_bits = '0; sprite_data = '0; scan_row = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy),   64'd0);
        check("rst_done", 64'(done),   64'd0);
        check("rst_vf",   64'(vf_out), 64'd0);
        check("rst_scan", scan_data,   64'd0);

        run_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, '0, 0, "clear");
        scan_all("clear");

        run_cmd(1'b0, 1'b1, 8'd0, 8'd0, 4'd5, ZERO_GLYPH, 0, "glyph");
        read_row(0, v);
        check("glyph_r0", v, 64'hF000_0000_0000_0000);
        read_row(1, v);
        check("glyph_r1", v, 64'h9000_0000_0000_0000);
        scan_all("glyph");

        run_cmd(1'b0, 1'b1, 8'd0, 8'd0, 4'd5, ZERO_GLYPH, 0, "erase");
        check("erase_vf1", 64'(vf_out), 64'h01);
        scan_all("erase");

        run_cmd(1'b0, 1'b1, 8'd62, 8'd30, 4'd3, {8'hFF, 8'hFF, 8'hFF, 96'h0}, 0, "edge");
`ifdef SPRITE_WRAP_EN
        exp_edge = 64'hFC00_0000_0000_0003;
`else
        exp_edge = 64'h0000_0000_0000_0003;
`endif
        read_row(30, v);
        check("edge_r30", v, exp_edge);
        scan_all("edge");

        run_cmd(1'b1, 1'b1, 8'd3, 8'd3, 4'd4, {32'hFFFF_FFFF, 88'h0}, 0, "both");
        scan_all("both");

        run_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd8, {64'hFFFF_FFFF_FFFF_FFFF, 56'h0}, 5, "busydraw");
        scan_all("busydraw");

        run_cmd(1'b0, 1'b1, 8'd10, 8'd4, 4'd5, ZERO_GLYPH, 0, "pre0a");
        run_cmd(1'b0, 1'b1, 8'd10, 8'd4, 4'd5, ZERO_GLYPH, 0, "pre0b");
        run_cmd(1'b0, 1'b1, 8'd20, 8'd9, 4'd0, ZERO_GLYPH, 0, "nzero");

        run_cmd(1'b0, 1'b1, 8'd1, 8'd2, 4'd7, {56'hFF_FF_FF_FF_FF_FF_FF, 64'h0}, 0, "fill");
        @(negedge clk);
        gpu_draw = 1'b1; vx = 8'd0; vy = 8'd0; n_bits = 4'd10; sprite_data = {120{1'b1}};
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        gpu_draw = 1'b0;
        model_reset();
        check("abort_busy", 64'(busy),   64'd0);
        check("abort_done", 64'(done),   64'd0);
        check("abort_vf",   64'(vf_out), 64'd0);
        @(negedge clk);
        check("abort_nodone", 64'(done), 64'd0);
        scan_all("abort");

        run_cmd(1'b0, 1'b1, 8'd70, 8'd3, 4'd1, {8'h80, 112'h0}, 0, "vx70");
        read_row(3, v);
        check("vx70_r3", v, 64'h0200_0000_0000_0000);

        for (int k = 0; k < 40; k++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            c = ($urandom_range(0, 7) == 0);
            d = c ? 1'($urandom_range(0, 1)) : 1'b1;
            run_cmd(c, d, 8'($urandom()), 8'($urandom()), 4'($urandom_range(0, 15)),
                    rnd[119:0], 0, $sformatf("rnd%0d", k));
            scan_all($sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
